// File: rtl/ld_time_sync_loader.sv
// ld_time_sync_loader
//
// Purpose: holds a free-running sample timestamp counter in the user_clk
// domain. A software arm (rising edge of `arm`) captures the load words.
// The next rising edge of the external sync pulse then loads the counter
// with {ld_time_msw, ld_time_lsw}, truncated to CNT_WIDTH bits. Armed and
// loaded status is reported back to software.
//
// Parameters:
//   CNT_WIDTH    timestamp width, 33..64
//   ARM_TIMEOUT  ARMED cycles without a sync edge before the arm is
//                abandoned; 0 disables the timeout
//
// Ports:
//   user_clk       in   sole clock, rising edge
//   user_rst_n     in   asynchronous active-low reset
//   ld_time_msw    in   upper 32 bits of the load value
//   ld_time_lsw    in   lower 32 bits of the load value
//   arm            in   software arm level (rising edge = arm event)
//   sync_in        in   external sync level (rising edge = sync event)
//   timestamp_out  out  current timestamp
//   ts_valid       out  high once any load has completed
//   armed          out  high while waiting for a sync edge
//   loaded_pulse   out  one-cycle strobe when the loaded value appears
//   load_count     out  completed loads, saturating at 0xFFFF
//   timeout_flag   out  sticky arm-timeout indication, cleared by next arm
//
// Build option: define LD_TIME_SYNC_CDC_EN to pass sync_in through a
// 2-flop synchroniser (sync edge to load latency becomes 3 cycles).
// Leave it undefined only when sync_in is synchronous to user_clk.

module ld_time_sync_loader #(
  parameter int unsigned CNT_WIDTH   = 64,
  parameter logic [31:0] ARM_TIMEOUT = 32'd0
) (
  input  logic                 user_clk,
  input  logic                 user_rst_n,
  input  logic [31:0]          ld_time_msw,
  input  logic [31:0]          ld_time_lsw,
  input  logic                 arm,
  input  logic                 sync_in,
  output logic [CNT_WIDTH-1:0] timestamp_out,
  output logic                 ts_valid,
  output logic                 armed,
  output logic                 loaded_pulse,
  output logic [15:0]          load_count,
  output logic                 timeout_flag
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_RUNNING
  } state_t;

  state_t state;
  state_t state_next;

  logic                 sync_s;
  logic                 arm_prev;
  logic                 sync_prev;
  logic                 arm_evt;
  logic                 sync_evt;
  logic [63:0]          ld_word;
  logic [CNT_WIDTH-1:0] hold;
  logic                 from_idle;
  logic [31:0]          tmo_cnt;
  logic                 tmo_expire;
  logic                 do_capture;
  logic                 do_load;
  logic                 do_timeout;

`ifdef LD_TIME_SYNC_CDC_EN
  logic sync_meta;
  logic sync_sync;

  // Synchroniser flops reset high so a sync level already high at reset
  // release is not mistaken for an edge.
  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      sync_meta <= 1'b1;
      sync_sync <= 1'b1;
    end else begin
      sync_meta <= sync_in;
      sync_sync <= sync_meta;
    end
  end

  assign sync_s = sync_sync;
`else
  assign sync_s = sync_in;
`endif

  // Previous-sample flops reset high: a level high at reset release is not an event.
  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      arm_prev  <= 1'b1;
      sync_prev <= 1'b1;
    end else begin
      arm_prev  <= arm;
      sync_prev <= sync_s;
    end
  end

  assign arm_evt  = arm & ~arm_prev;
  assign sync_evt = sync_s & ~sync_prev;
  assign ld_word  = {ld_time_msw, ld_time_lsw};

  // Expiry fires in the ARM_TIMEOUT-th cycle spent in ARMED.
  assign tmo_expire = (ARM_TIMEOUT != 32'd0) &&
                      (({1'b0, tmo_cnt} + 33'd1) == {1'b0, ARM_TIMEOUT});

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // In ARMED a sync edge beats both a coincident arm edge and expiry.
  always_comb begin
    state_next = state;
    do_capture = 1'b0;
    do_load    = 1'b0;
    do_timeout = 1'b0;
    case (state)
      ST_IDLE, ST_RUNNING: begin
        if (arm_evt) begin
          do_capture = 1'b1;
          state_next = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (sync_evt) begin
          do_load    = 1'b1;
          state_next = ST_RUNNING;
        end else if (arm_evt) begin
          do_capture = 1'b1;
        end else if (tmo_expire) begin
          do_timeout = 1'b1;
          state_next = from_idle ? ST_IDLE : ST_RUNNING;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      hold          <= '0;
      from_idle     <= 1'b0;
      tmo_cnt       <= '0;
      timeout_flag  <= 1'b0;
      timestamp_out <= '0;
      ts_valid      <= 1'b0;
      armed         <= 1'b0;
      loaded_pulse  <= 1'b0;
      load_count    <= '0;
    end else begin
      if (do_capture) begin
        hold         <= ld_word[CNT_WIDTH-1:0];
        tmo_cnt      <= '0;
        timeout_flag <= 1'b0;
        // A re-arm inside ARMED keeps the state to fall back to.
        if (state != ST_ARMED) begin
          from_idle <= (state == ST_IDLE);
        end
      end else if (state == ST_ARMED && ARM_TIMEOUT != 32'd0) begin
        tmo_cnt <= tmo_cnt + 32'd1;
      end

      if (do_timeout) begin
        timeout_flag <= 1'b1;
      end

      if (do_load) begin
        timestamp_out <= hold;
      end else if (state != ST_IDLE) begin
        timestamp_out <= timestamp_out + 1'b1;
      end

      loaded_pulse <= do_load;
      armed        <= (state_next == ST_ARMED);

      if (do_load) begin
        ts_valid <= 1'b1;
        if (load_count != 16'hFFFF) begin
          load_count <= load_count + 16'd1;
        end
      end
    end
  end

endmodule
